cnn_conv_top: RTL and testbench

//  Standalone CNN layer engine: reads bias, kernels and ifmap from an external 1K x 64b DRAM, computes
//  6-channel 3x3 conv + bias + ReLU + 2x2 max-pool, and writes 8-bit results back to the same DRAM.

---
 rtl/cnn_pkg.sv | 34 +++
 rtl/conv_pe.sv | 21 ++
 rtl/cnn_conv_top.sv | 192 +++++++++++++++++++
 tb/tb_cnn_conv_top.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants, state encoding and data types for the CNN conv/pool engine.
package cnn_pkg;

  localparam int IMG_W          = 30;
  localparam int NUM_CH         = 6;
  localparam int POOL_W         = 14;
  localparam int SHIFT          = 4;

  localparam int BIAS_BASE      = 0;
  localparam int KER_BASE       = 2;
  localparam int IFM_BASE       = 9;
  localparam int IFM_LAST       = 121;
  localparam int OUT_BASE       = 238;
  localparam int DONE_ADDR      = 398;

  localparam int BIAS_WORDS     = 2;
  localparam int KER_WORDS      = 7;
  localparam int IMG_WORDS      = 113;
  localparam int OUT_DATA_WORDS = 147;
  localparam int OUT_WORDS      = 150;

  typedef logic        [7:0]  pix_t;
  typedef logic signed [7:0]  wgt_t;
  typedef logic signed [20:0] acc_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/conv_pe.sv
// 3x3 MAC (unsigned pixels x signed weights) plus bias, ReLU and arithmetic shift.
module conv_pe
  import cnn_pkg::*;
(
  input  logic [8:0][7:0]     pix,
  input  logic [8:0][7:0]     wgt,
  input  logic signed [15:0]  bias,
  output acc_t                v
);

  acc_t acc;

  always_comb begin
    acc = acc_t'(bias);
    for (int t = 0; t < 9; t++) begin
      acc = acc + acc_t'({1'b0, pix[4'(t)]}) * acc_t'($signed(wgt[4'(t)]));
    end
    v = acc[20] ? '0 : (acc >>> SHIFT);
  end

endmodule

// File: rtl/cnn_conv_top.sv
// Single-shot 6-channel 3x3 conv + bias + ReLU + 2x2 max-pool engine on one 64b DRAM port.
// Build option SATURATE_EN: clamp pooled values to 255 instead of keeping the low byte.
//
// state   | meaning
// IDLE    | first cycle after reset release
// LOAD    | stream words 0..121 into bias / weight / image buffers
// COMPUTE | one conv position per cycle, pool max and byte packing
// WRITE   | emit one finished output word (or a trailing zero word)
// DONE    | completion marker written, port quiet
module cnn_conv_top
  import cnn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] ifmap,
  output logic        DRAMreadEn,
  output logic [9:0]  DRAMreadAddr,
  output logic        DRAMwriteEn,
  output logic [9:0]  DRAMwriteAddr,
  output logic [63:0] DRAMwriteData
);

  state_t state, nstate;

  logic        pend;
  logic [9:0]  pend_addr;
  logic [63:0] bias_buf [0:BIAS_WORDS-1];
  logic [63:0] wgt_buf  [0:KER_WORDS-1];
  logic [63:0] img_buf  [0:IMG_WORDS-1];

  logic [2:0]  ch;
  logic [3:0]  pr, pc;
  logic [1:0]  q;
  logic [2:0]  bcnt;
  logic [7:0]  out_word;
  logic        done_wr;
  logic [63:0] pack;
  acc_t        pmax, pool_v, pe_v;
  logic [7:0]  pool_byte;

  logic [4:0]  row, col;
  logic [9:0]  base, pidx;
  logic [5:0]  wbase, widx;
  logic [8:0][7:0]    pe_pix, pe_wgt;
  logic signed [15:0] pe_bias;
  logic        load_last, word_full;

  // Conv position (2pr+dy, 2pc+dx) is just the pool index with the quadrant bit appended.
  assign row  = {pr, q[1]};
  assign col  = {pc, q[0]};
  assign base = 10'(row) * 10'(IMG_W) + 10'(col);

  always_comb begin
    wbase  = 6'(ch) * 6'd9;
    pidx   = base;
    widx   = wbase;
    pe_pix = '0;
    pe_wgt = '0;
    for (int t = 0; t < 9; t++) begin
      pidx = base + 10'((t / 3) * IMG_W + (t % 3));
      widx = wbase + 6'(t);
      pe_pix[4'(t)] = img_buf[pidx[9:3]][{pidx[2:0], 3'b000} +: 8];
      pe_wgt[4'(t)] = wgt_buf[widx[5:3]][{widx[2:0], 3'b000} +: 8];
    end
  end

  assign pe_bias = bias_buf[ch[2]][{ch[1:0], 4'b0000} +: 16];

  conv_pe u_pe (
    .pix  (pe_pix),
    .wgt  (pe_wgt),
    .bias (pe_bias),
    .v    (pe_v)
  );

  assign pool_v = (q == 2'd0 || pe_v > pmax) ? pe_v : pmax;

`ifdef SATURATE_EN
  assign pool_byte = (pool_v > acc_t'(255)) ? 8'hFF : pool_v[7:0];
`else
  assign pool_byte = pool_v[7:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate    = state;
    load_last = pend && (pend_addr == 10'(IFM_LAST));
    word_full = (q == 2'd3) && (bcnt == 3'd7);
    case (state)
      IDLE:    nstate = LOAD;
      LOAD:    if (load_last) nstate = COMPUTE;
      COMPUTE: if (word_full) nstate = WRITE;
      WRITE: begin
        if (out_word == 8'(OUT_WORDS - 1))           nstate = DONE;
        else if (out_word >= 8'(OUT_DATA_WORDS - 1)) nstate = WRITE;
        else                                         nstate = COMPUTE;
      end
      DONE:    nstate = DONE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      DRAMreadEn    <= 1'b0;
      DRAMreadAddr  <= '0;
      DRAMwriteEn   <= 1'b0;
      DRAMwriteAddr <= '0;
      DRAMwriteData <= '0;
      pend          <= 1'b0;
      pend_addr     <= '0;
      ch            <= '0;
      pr            <= '0;
      pc            <= '0;
      q             <= '0;
      bcnt          <= '0;
      out_word      <= '0;
      done_wr       <= 1'b0;
      pack          <= '0;
      pmax          <= '0;
      for (int k = 0; k < BIAS_WORDS; k++) bias_buf[k] <= '0;
      for (int k = 0; k < KER_WORDS; k++)  wgt_buf[k]  <= '0;
      for (int k = 0; k < IMG_WORDS; k++)  img_buf[k]  <= '0;
    end else begin
      DRAMwriteEn <= 1'b0;
      pend        <= DRAMreadEn;
      pend_addr   <= DRAMreadAddr;

      case (state)
        IDLE: begin
          DRAMreadEn   <= 1'b1;
          DRAMreadAddr <= '0;
        end
        LOAD: begin
          if (DRAMreadEn) begin
            if (DRAMreadAddr == 10'(IFM_LAST)) DRAMreadEn   <= 1'b0;
            else                               DRAMreadAddr <= DRAMreadAddr + 10'd1;
          end
        end
        COMPUTE: begin
          pmax <= pool_v;
          q    <= q + 2'd1;
          if (q == 2'd3) begin
            pack <= {pool_byte, pack[63:8]};
            bcnt <= bcnt + 3'd1;
            if (pc == 4'(POOL_W - 1)) begin
              pc <= '0;
              if (pr == 4'(POOL_W - 1)) begin
                pr <= '0;
                ch <= (ch == 3'(NUM_CH - 1)) ? 3'd0 : ch + 3'd1;
              end else begin
                pr <= pr + 4'd1;
              end
            end else begin
              pc <= pc + 4'd1;
            end
          end
        end
        WRITE: begin
          DRAMwriteEn   <= 1'b1;
          DRAMwriteAddr <= 10'(OUT_BASE) + 10'(out_word);
          DRAMwriteData <= (out_word < 8'(OUT_DATA_WORDS)) ? pack : 64'd0;
          out_word      <= out_word + 8'd1;
        end
        DONE: begin
          if (!done_wr) begin
            DRAMwriteEn   <= 1'b1;
            DRAMwriteAddr <= 10'(DONE_ADDR);
            DRAMwriteData <= '0;
            done_wr       <= 1'b1;
          end
        end
        default: ;
      endcase

      // Read data for a request issued last cycle is on ifmap now.
      if (pend) begin
        if (pend_addr < 10'(KER_BASE))
          bias_buf[1'(pend_addr - 10'(BIAS_BASE))] <= ifmap;
        else if (pend_addr < 10'(IFM_BASE))
          wgt_buf[3'(pend_addr - 10'(KER_BASE))] <= ifmap;
        else
          img_buf[7'(pend_addr - 10'(IFM_BASE))] <= ifmap;
      end
    end
  end

endmodule

// File: tb/tb_cnn_conv_top.sv
// Bench for cnn_conv_top: behavioural DRAM, golden conv/pool model and an ordered write scoreboard.
module tb_cnn_conv_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] ifmap = '0;
  logic        DRAMreadEn;
  logic [9:0]  DRAMreadAddr;
  logic        DRAMwriteEn;
  logic [9:0]  DRAMwriteAddr;
  logic [63:0] DRAMwriteData;

  always #5 clk = ~clk;

  cnn_conv_top dut (
    .clk           (clk),
    .rst           (rst),
    .ifmap         (ifmap),
    .DRAMreadEn    (DRAMreadEn),
    .DRAMreadAddr  (DRAMreadAddr),
    .DRAMwriteEn   (DRAMwriteEn),
    .DRAMwriteAddr (DRAMwriteAddr),
    .DRAMwriteData (DRAMwriteData)
  );

  logic [63:0] mem [0:1023];
  logic        req_en = 1'b0;
  logic [9:0]  req_addr = '0;

  // Request seen at the end of cycle n is returned on the falling edge inside cycle n+1.
  always @(posedge clk) begin
    req_en   <= DRAMreadEn;
    req_addr <= DRAMreadAddr;
  end
  always @(negedge clk) if (req_en) ifmap <= mem[req_addr];

  typedef struct packed {
    logic [9:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t   exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  string cur_tag;
  int    p_arr [900];
  int    w_arr [54];
  int    b_arr [6];

  task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_case(input int t);
    for (int k = 0; k < 6; k++) b_arr[k] = 0;
    for (int k = 0; k < 54; k++) w_arr[k] = 0;
    for (int k = 0; k < 900; k++) p_arr[k] = 0;
    case (t)
      1: begin for (int k = 0; k < 900; k++) p_arr[k] = 1;   for (int k = 0; k < 54; k++) w_arr[k] = 1;   end
      2: begin for (int k = 0; k < 900; k++) p_arr[k] = 16;  for (int k = 0; k < 54; k++) w_arr[k] = 1;   end
      3: begin
        for (int k = 0; k < 6; k++) b_arr[k] = 16 * k;
        for (int k = 0; k < 900; k++) p_arr[k] = int'($urandom_range(0, 255));
      end
      4: begin for (int k = 0; k < 900; k++) p_arr[k] = 255; for (int k = 0; k < 54; k++) w_arr[k] = 127; end
      5: begin for (int k = 0; k < 900; k++) p_arr[k] = 200; for (int k = 0; k < 54; k++) w_arr[k] = -1;  end
      6: begin
        for (int k = 0; k < 6; k++)   b_arr[k] = int'($urandom_range(0, 1000)) - 500;
        for (int k = 0; k < 54; k++)  w_arr[k] = int'($urandom_range(0, 60)) - 20;
        for (int k = 0; k < 900; k++) p_arr[k] = int'($urandom_range(0, 255));
      end
      default: ;
    endcase
  endtask

  task automatic load_mem();
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    for (int k = 0; k < 6; k++)   mem[k / 4][16 * (k % 4) +: 16] = 16'(b_arr[k]);
    for (int k = 0; k < 54; k++)  mem[2 + k / 8][8 * (k % 8) +: 8] = 8'(w_arr[k]);
    for (int k = 0; k < 900; k++) mem[9 + k / 8][8 * (k % 8) +: 8] = 8'(p_arr[k]);
  endtask

  task automatic push_golden();
    logic [63:0] word;
    logic [7:0]  by;
    int k, c, pr, pc, acc, v, best;
    exp_q.delete();
    for (int wd = 0; wd < 150; wd++) begin
      word = '0;
      for (int jb = 0; jb < 8; jb++) begin
        k  = wd * 8 + jb;
        by = 8'd0;
        if (k < 1176) begin
          c    = k / 196;
          pr   = (k % 196) / 14;
          pc   = k % 14;
          best = 0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              acc = b_arr[c];
              for (int i = 0; i < 3; i++)
                for (int jj = 0; jj < 3; jj++)
                  acc += p_arr[(2 * pr + dy + i) * 30 + 2 * pc + dx + jj] * w_arr[9 * c + 3 * i + jj];
              v = (acc < 0) ? 0 : acc / 16;
              if (v > best) best = v;
            end
`ifdef SATURATE_EN
          by = (best > 255) ? 8'hFF : 8'(best);
`else
          by = 8'(best);
`endif
        end
        word[8 * jb +: 8] = by;
      end
      exp_q.push_back({10'(238 + wd), word});
    end
    exp_q.push_back({10'd398, 64'd0});
  endtask

  task automatic start_run();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    load_mem();
    push_golden();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Runs until the done marker (stop_writes == 0) or until stop_writes writes were observed.
  task automatic run_dut(input int stop_writes, input int max_cyc);
    bit  done = 0;
    bit  ovl = 0;
    int  nwr = 0;
    wr_t e;
    for (int n = 0; n < max_cyc && !done; n++) begin
      @(negedge clk);
      if (DRAMreadEn && DRAMwriteEn) ovl = 1;
      if (DRAMwriteEn) begin
        nwr++;
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_fail++;
          $error("FAIL %s unexpected write observed addr=%0d expected none", cur_tag, DRAMwriteAddr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(cur_tag, {DRAMwriteAddr, DRAMwriteData}, e);
        end
        if (DRAMwriteAddr == 10'd398) done = 1;
        if (stop_writes != 0 && nwr >= stop_writes) done = 1;
      end
    end
    check({cur_tag, "_finished"}, 74'(done), 74'd1);
    check({cur_tag, "_rw_overlap"}, 74'(ovl), 74'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_readEn"},    74'(DRAMreadEn),    74'd0);
    check({tag, "_readAddr"},  74'(DRAMreadAddr),  74'd0);
    check({tag, "_writeEn"},   74'(DRAMwriteEn),   74'd0);
    check({tag, "_writeAddr"}, 74'(DRAMwriteAddr), 74'd0);
    check({tag, "_writeData"}, 74'(DRAMwriteData), 74'd0);
  endtask

  task automatic check_after_done();
    repeat (4) @(negedge clk);
    check({cur_tag, "_post_readEn"},    74'(DRAMreadEn),    74'd0);
    check({cur_tag, "_post_writeEn"},   74'(DRAMwriteEn),   74'd0);
    check({cur_tag, "_post_writeAddr"}, 74'(DRAMwriteAddr), 74'd398);
    check({cur_tag, "_queue_empty"},    74'(exp_q.size()),  74'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");

    for (int t = 0; t < 7; t++) begin
      cur_tag = $sformatf("case%0d", t);
      set_case(t);
      start_run();
      run_dut(0, 20000);
      check_after_done();
    end

    // Abort mid-COMPUTE, then rerun the same data to completion.
    cur_tag = "abort";
    set_case(6);
    start_run();
    run_dut(12, 20000);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_idle_outputs("abort_reset");
    cur_tag = "rerun";
    start_run();
    run_dut(0, 20000);
    check_after_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
